crc_serial_checker_gen: RTL and testbench
=========================================

Name: crc_serial_checker_gen

Overview:
- Parametrised bit-serial CRC engine for the BLE/Bluetooth RX payload path. It generalises the fixed CRC-16 de-CRC checker in CRC width, generator polynomial and seed mapping.
- A framed transaction does three things in order: absorbs a programmed number of payload bits, then serially compares the received CRC field, then reports pass/fail.
- Sits between the demodulated bit stream and the packet-status logic.

Parameters:
- CRC_LEN, 16, CRC register width (legal 8..32).
- POLY, 16'h1021, generator taps excluding the x^CRC_LEN term (CRC_LEN bits wide).
- SEED_W, 8, width of seed port (SEED_W <= CRC_LEN).
- SEED_REVERSE, 1, 1: crc_reg[i] = seed[SEED_W-1-i]; 0: crc_reg[i] = seed[i]. Remaining upper bits are 0.
- LEN_W, 12, width of payload bit-count port.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, asynchronous active-low reset.
- start, input, 1, one-cycle pulse: load seed, latch payload_bits, begin frame.
- seed, input, SEED_W, CRC initial value (UAP/DCI).
- payload_bits, input, LEN_W, number of payload bits before the CRC field.
- abort, input, 1, cancel the frame.
- data_in, input, 1, serial bit.
- valid_in, input, 1, data_in qualifier.
- busy, output, 1, high in PAYLOAD/CHECK/DONE.
- crc_value, output, CRC_LEN, CRC computed over the payload; frozen at the end of PAYLOAD.
- done, output, 1, one-cycle pulse: result valid.
- crc_ok, output, 1, frame passed; held until next start/abort.
- crc_err, output, 1, frame failed; held until next start/abort.

Behaviour:
- Reset values: state=IDLE, crc_reg=seed mapping of the live seed port, bit_cnt=0, crc_value=0, busy=0, done=0, crc_ok=0, crc_err=0, mismatch=0.
- Update rule, per accepted payload bit:
  - fb = crc_reg[CRC_LEN-1] ^ data_in
  - crc_reg <= {crc_reg[CRC_LEN-2:0],1'b0} ^ (fb ? POLY : 0)
- States: IDLE, PAYLOAD, CHECK, DONE.
- IDLE:
  - On start: load crc_reg from the seed mapping, bit_cnt <= payload_bits, clear crc_ok/crc_err/mismatch.
  - Next state is PAYLOAD, or CHECK if payload_bits==0. In the CHECK case, crc_value <= seed mapping.
  - valid_in is ignored in IDLE.
- PAYLOAD:
  - Each cycle with valid_in=1 applies the update rule and decrements bit_cnt.
  - valid_in=0 stalls; state and registers are held.
  - On the bit where bit_cnt==1: crc_value <= updated crc_reg, bit_cnt <= CRC_LEN, go to CHECK.
- CHECK:
  - Each cycle with valid_in=1:
    - mismatch <= mismatch | (data_in ^ crc_reg[CRC_LEN-1])
    - crc_reg <= crc_reg<<1 (shifts in 0)
    - bit_cnt decrements.
  - The received CRC is compared MSB first. Stalls behave as in PAYLOAD.
  - On the last bit (bit_cnt==1), go to DONE.
- DONE (exactly one cycle):
  - done=1; crc_ok = ~mismatch_final; crc_err = mismatch_final. mismatch_final includes the last compared bit.
  - Next state is IDLE; crc_ok/crc_err hold.
- Latency: done is asserted on the cycle after the edge that accepts the last CRC bit.
- start while busy (any non-IDLE state, including DONE): restart immediately with the new seed and length. No done pulse for the killed frame.
- abort: has priority over valid_in. State goes to IDLE, crc_ok/crc_err/mismatch clear, no done pulse. If abort and start are asserted in the same cycle, abort wins.
- crc_value stays stable from the end of PAYLOAD until the next start.
- Asynchronous reset mid-frame: returns to IDLE at once; all outputs take their reset values.

Test Plan:
- seed=8'h00, payload_bits=1, bit '1' -> crc_value=16'h1021. Then feed check bits 16'h1021 MSB first -> done pulse one cycle after the 16th bit, crc_ok=1, crc_err=0.
- seed=8'h00, payload_bits=2, bits '1','0' -> crc_value=16'h2042. Feed 16'h2042 with bit 9 flipped -> crc_err=1, crc_ok=0. Both hold after done.
- SEED_REVERSE=1, seed=8'h01, payload_bits=0 -> crc_value=16'h0080, state goes straight to CHECK. Feed 16'h0080 -> crc_ok=1.
- Stalls: repeat the first test with valid_in toggled 0/1 every other cycle -> identical crc_value and result; done is delayed by the stall count.
- abort asserted mid-CHECK -> busy=0 next cycle, no done, crc_ok=crc_err=0. A new start mid-PAYLOAD reseeds, and only the second frame produces done.
- Assert reset low mid-PAYLOAD -> busy/done/crc_ok/crc_err=0 and crc_value=0 immediately, asynchronously.

Source files
------------

// File: rtl/crc_serial_checker_gen.sv
// Bit-serial CRC checker for the RX payload path.
// A frame absorbs payload_bits payload bits into the CRC register, then compares
// the received CRC field (MSB first) against the register, then reports pass/fail.
module crc_serial_checker_gen #(
    parameter int                  CRC_LEN      = 16,
    parameter logic [CRC_LEN-1:0]  POLY         = 16'h1021,
    parameter int                  SEED_W       = 8,
    parameter bit                  SEED_REVERSE = 1'b1,
    parameter int                  LEN_W        = 12
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [SEED_W-1:0]  seed,
    input  logic [LEN_W-1:0]   payload_bits,
    input  logic               abort,
    input  logic               data_in,
    input  logic               valid_in,
    output logic               busy,
    output logic [CRC_LEN-1:0] crc_value,
    output logic               done,
    output logic               crc_ok,
    output logic               crc_err
);

    // bit_cnt holds either the payload length or the CRC field length
    localparam int CRC_CW = $clog2(CRC_LEN + 1);
    localparam int CNT_W  = (LEN_W > CRC_CW) ? LEN_W : CRC_CW;

    typedef enum logic [1:0] {IDLE, PAYLOAD, CHECK, DONE} state_t;

    state_t             state, state_nxt;
    logic [CRC_LEN-1:0] crc_reg;
    logic [CRC_LEN-1:0] seed_map;
    logic [CRC_LEN-1:0] crc_next;
    logic [CNT_W-1:0]   bit_cnt;
    logic               mismatch;
    logic               last_bit;
    logic               bit_miss;
    logic               len_zero;

    // Seed placement into the low bits of the CRC register; upper bits stay zero
    always_comb begin
        seed_map = '0;
        for (int i = 0; i < SEED_W; i++)
            seed_map[i] = SEED_REVERSE ? seed[SEED_W-1-i] : seed[i];
    end

    // One LFSR step for the current payload bit, plus per-bit helpers
    always_comb begin
        crc_next = {crc_reg[CRC_LEN-2:0], 1'b0} ^
                   ((crc_reg[CRC_LEN-1] ^ data_in) ? POLY : '0);
        last_bit = (bit_cnt == CNT_W'(1));
        bit_miss = data_in ^ crc_reg[CRC_LEN-1];
        len_zero = (payload_bits == '0);
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state: abort beats start, start restarts from any state
    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = IDLE;
        end else if (start) begin
            state_nxt = len_zero ? CHECK : PAYLOAD;
        end else begin
            case (state)
                PAYLOAD: if (valid_in && last_bit) state_nxt = CHECK;
                CHECK:   if (valid_in && last_bit) state_nxt = DONE;
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Datapath: CRC register, bit counter, result flags and the frozen CRC value
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            crc_reg   <= seed_map;
            bit_cnt   <= '0;
            crc_value <= '0;
            crc_ok    <= 1'b0;
            crc_err   <= 1'b0;
            mismatch  <= 1'b0;
        end else if (abort) begin
            crc_ok   <= 1'b0;
            crc_err  <= 1'b0;
            mismatch <= 1'b0;
        end else if (start) begin
            crc_reg  <= seed_map;
            bit_cnt  <= CNT_W'(payload_bits);
            crc_ok   <= 1'b0;
            crc_err  <= 1'b0;
            mismatch <= 1'b0;
            if (len_zero) begin
                crc_value <= seed_map;
                bit_cnt   <= CNT_W'(CRC_LEN);
            end
        end else if (valid_in) begin
            case (state)
                PAYLOAD: begin
                    crc_reg <= crc_next;
                    bit_cnt <= bit_cnt - CNT_W'(1);
                    if (last_bit) begin
                        crc_value <= crc_next;
                        bit_cnt   <= CNT_W'(CRC_LEN);
                    end
                end
                CHECK: begin
                    crc_reg  <= {crc_reg[CRC_LEN-2:0], 1'b0};
                    bit_cnt  <= bit_cnt - CNT_W'(1);
                    mismatch <= mismatch | bit_miss;
                    // Result flags land together with the DONE state so they are
                    // valid during the done pulse and hold afterwards
                    if (last_bit) begin
                        crc_ok  <= ~(mismatch | bit_miss);
                        crc_err <= mismatch | bit_miss;
                    end
                end
                default: ;
            endcase
        end
    end

    // Status decoded straight from the state
    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

endmodule

// File: tb/tb_crc_serial_checker_gen.sv
// Randomized self-checking bench for crc_serial_checker_gen.
// Reference: CRC-16 (x^16+x^12+x^5+1) division of the payload stream with a
// bit-reversed 8-bit seed; a frame passes iff the received field equals it.
module tb_crc_serial_checker_gen;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  seed = '0;
    logic [11:0] payload_bits = '0;
    logic        abort = 1'b0;
    logic        data_in = 1'b0;
    logic        valid_in = 1'b0;
    logic        busy;
    logic [15:0] crc_value;
    logic        done;
    logic        crc_ok;
    logic        crc_err;

    int n_vec = 0;
    int n_miss = 0;

    crc_serial_checker_gen #(
        .CRC_LEN(16), .POLY(16'h1021), .SEED_W(8), .SEED_REVERSE(1'b1), .LEN_W(12)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .seed(seed),
        .payload_bits(payload_bits), .abort(abort), .data_in(data_in),
        .valid_in(valid_in), .busy(busy), .crc_value(crc_value), .done(done),
        .crc_ok(crc_ok), .crc_err(crc_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Remainder of the seeded message against the generator, one message bit at a time
    function automatic logic [15:0] ref_crc(input logic [7:0] sd, input int len,
                                            input logic [63:0] pay);
        int r = 0;
        for (int i = 0; i < 8; i++)
            if (sd[i]) r = r | (1 << (7 - i));
        for (int i = 0; i < len; i++) begin
            int top = (r >> 15) & 1;
            r = (r << 1) & 32'hFFFF;
            if ((top ^ int'(pay[i])) != 0) r = r ^ 32'h1021;
        end
        return 16'(r);
    endfunction

    // stall: 0 none, 1 alternate idle/valid cycles, 2 random idle cycles
    task automatic feed_bit(input logic b, input int stall, inout int phase);
        if (stall == 1 || (stall == 2 && $urandom_range(0, 3) == 0)) begin
            if (stall == 1) phase = phase ^ 1;
            if (stall == 2 || phase == 1) begin
                valid_in = 1'b0;
                data_in  = 1'($urandom);
                step();
            end
        end
        valid_in = 1'b1;
        data_in  = b;
        step();
        valid_in = 1'b0;
    endtask

    task automatic pulse_start(input logic [7:0] sd, input int len);
        seed         = sd;
        payload_bits = 12'(len);
        start        = 1'b1;
        step();
        start        = 1'b0;
    endtask

    // Full frame: payload, received field (optionally with one bit flipped), result
    task automatic run_frame(input string tag, input logic [7:0] sd, input int len,
                             input logic [63:0] pay, input int flip_pos, input int stall);
        logic [15:0] exp_crc;
        logic [15:0] rx;
        logic        bad;
        int          phase = 0;
        exp_crc = ref_crc(sd, len, pay);
        bad     = (flip_pos >= 0);
        rx      = exp_crc;
        if (bad) rx[flip_pos] = ~rx[flip_pos];
        pulse_start(sd, len);
        chk({tag, " busy"}, 32'(busy), 32'd1);
        for (int i = 0; i < len; i++) feed_bit(pay[i], stall, phase);
        chk({tag, " crc_value"}, 32'(crc_value), 32'(exp_crc));
        for (int i = 15; i >= 0; i--) begin
            if (i == 0) chk({tag, " early done"}, 32'(done), 32'd0);
            feed_bit(rx[i], stall, phase);
        end
        chk({tag, " done"}, 32'(done), 32'd1);
        chk({tag, " crc_ok"}, 32'(crc_ok), 32'(!bad));
        chk({tag, " crc_err"}, 32'(crc_err), 32'(bad));
        step();
        chk({tag, " done drop"}, 32'(done), 32'd0);
        chk({tag, " hold"}, {14'd0, busy, crc_ok, crc_value}, {15'd0, !bad, exp_crc});
    endtask

    initial begin
        #12;
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst flags", {30'd0, crc_ok, crc_err}, 32'd0);
        chk("rst crc_value", 32'(crc_value), 32'd0);
        reset = 1'b1;
        step();

        run_frame("t1", 8'h00, 1, 64'h1, -1, 0);
        chk("t1 value", 32'(crc_value), 32'h1021);
        run_frame("t2", 8'h00, 2, 64'h1, 9, 0);
        chk("t2 value", 32'(crc_value), 32'h2042);
        step();
        chk("t2 err holds", {30'd0, crc_ok, crc_err}, 32'd1);

        pulse_start(8'h01, 0);
        chk("t3 crc_value", 32'(crc_value), 32'h0080);
        run_frame("t3", 8'h01, 0, 64'h0, -1, 0);

        run_frame("t4 stall", 8'h00, 1, 64'h1, -1, 1);
        chk("t4 value", 32'(crc_value), 32'h1021);

        // Abort mid-CHECK, with valid_in high to show abort wins
        pulse_start(8'hA5, 3);
        for (int i = 0; i < 3; i++) begin valid_in = 1'b1; data_in = 1'($urandom); step(); end
        for (int i = 0; i < 5; i++) begin valid_in = 1'b1; data_in = 1'($urandom); step(); end
        abort = 1'b1; start = 1'b1; valid_in = 1'b1;
        step();
        abort = 1'b0; start = 1'b0; valid_in = 1'b0;
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort flags", {30'd0, crc_ok, crc_err}, 32'd0);
        for (int i = 0; i < 20; i++) begin
            valid_in = 1'b1; data_in = 1'($urandom); step();
            if (done) chk("abort no done", 32'(done), 32'd0);
        end
        valid_in = 1'b0;
        chk("abort idle", 32'(busy), 32'd0);

        // Restart mid-PAYLOAD: the first frame must never produce done
        pulse_start(8'h3C, 10);
        for (int i = 0; i < 4; i++) begin valid_in = 1'b1; data_in = 1'($urandom); step(); end
        valid_in = 1'b0;
        run_frame("restart", 8'h5A, 12, 64'hABC, -1, 0);

        for (int k = 0; k < 24; k++) begin
            logic [63:0] pay;
            int len;
            int fp;
            pay = {$urandom, $urandom};
            len = $urandom_range(0, 48);
            fp  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 15)) : -1;
            run_frame("rand", 8'($urandom), len, pay, fp, int'($urandom_range(0, 2)));
        end

        // Asynchronous reset in the middle of a payload
        pulse_start(8'h77, 20);
        for (int i = 0; i < 5; i++) begin valid_in = 1'b1; data_in = 1'($urandom); step(); end
        valid_in = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("async busy", 32'(busy), 32'd0);
        chk("async done", 32'(done), 32'd0);
        chk("async flags", {30'd0, crc_ok, crc_err}, 32'd0);
        chk("async crc_value", 32'(crc_value), 32'd0);
        step();
        reset = 1'b1;
        step();
        run_frame("post rst", 8'h00, 1, 64'h1, -1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: run did not reach summary, want completion");
        $fatal(1);
    end

endmodule
